// File: rtl/supervisor_inactividad.sv
// supervisor_inactividad: idle-time supervisor that requests a return to the rest floor after a full idle minute.
// Optional SUPERVISOR_SINCRONIZA_EN adds two-flop synchronizers on pedidos_i and motorActivo_i.
module supervisor_inactividad #(
   parameter logic [13:0] DIVISOR     = 14'd9000,
   parameter int          N_PISOS     = 4,
   parameter logic [1:0]  PISO_REPOSO = 2'd1
) (
   input  logic               clockInt_150Hz_i,
   input  logic               resetN_i,
   input  logic [N_PISOS-1:0] pedidos_i,
   input  logic               motorActivo_i,
   input  logic [1:0]         pisoActual_i,
   input  logic [13:0]        cuenta_i,
   input  logic               ackReposo_i,
   output logic               iniciaCuenta_o,
   output logic               pedidoReposo_o,
   output logic [1:0]         pisoReposo_o,
   output logic               enReposo_o
);
   typedef enum logic [2:0] {
      OCUPADO   = 3'd0,
      CONTANDO  = 3'd1,
      SOLICITA  = 3'd2,
      TRASLADO  = 3'd3,
      EN_REPOSO = 3'd4
   } estado_t;
   estado_t estado_q, estado_d;
   logic [N_PISOS-1:0] pedidos;
   logic motor;
`ifdef SUPERVISOR_SINCRONIZA_EN
   logic [N_PISOS-1:0] ped_s1_q, ped_s2_q;
   logic mot_s1_q, mot_s2_q;
   always_ff @(posedge clockInt_150Hz_i or negedge resetN_i) begin
      if (!resetN_i) begin
         ped_s1_q <= '0;
         ped_s2_q <= '0;
         mot_s1_q <= 1'b0;
         mot_s2_q <= 1'b0;
      end else begin
         ped_s1_q <= pedidos_i;
         ped_s2_q <= ped_s1_q;
         mot_s1_q <= motorActivo_i;
         mot_s2_q <= mot_s1_q;
      end
   end
   assign pedidos = ped_s2_q;
   assign motor   = mot_s2_q;
`else
   assign pedidos = pedidos_i;
   assign motor   = motorActivo_i;
`endif
   logic actividad, en_piso, fin_cuenta;
   assign actividad  = (pedidos != '0) | motor;
   assign en_piso    = pisoActual_i == PISO_REPOSO;
   assign fin_cuenta = cuenta_i == DIVISOR - 14'd1;
   always_ff @(posedge clockInt_150Hz_i or negedge resetN_i) begin
      if (!resetN_i) estado_q <= OCUPADO;
      else           estado_q <= estado_d;
   end
   // Activity beats terminal count in CONTANDO; SOLICITA only leaves on ack.
   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         OCUPADO:   if (!actividad) estado_d = en_piso ? EN_REPOSO : CONTANDO;
         CONTANDO:  estado_d = actividad ? OCUPADO : fin_cuenta ? SOLICITA : CONTANDO;
         SOLICITA:  if (ackReposo_i) estado_d = TRASLADO;
         TRASLADO:  estado_d = (pedidos != '0) ? OCUPADO : (!motor && en_piso) ? EN_REPOSO : TRASLADO;
         EN_REPOSO: if (actividad) estado_d = OCUPADO;
         default:   estado_d = OCUPADO;
      endcase
   end
   always_comb begin
      iniciaCuenta_o = estado_q == CONTANDO;
      pedidoReposo_o = estado_q == SOLICITA;
      enReposo_o     = estado_q == EN_REPOSO;
      pisoReposo_o   = PISO_REPOSO;
   end
endmodule

// File: tb/tb_supervisor_inactividad.sv
// tb_supervisor_inactividad: vector table plus counter-model sequences for supervisor_inactividad.
module tb_supervisor_inactividad;
   localparam logic [13:0] DIV = 14'd9000;
`ifdef SUPERVISOR_SINCRONIZA_EN
   localparam int SYN = 2;
`else
   localparam int SYN = 0;
`endif
   typedef struct {
      logic [3:0]  p;
      logic        m;
      logic [1:0]  f;
      logic [13:0] c;
      logic        a;
      logic [2:0]  e;
   } vec_t;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [3:0] pedidos = '0;
   logic motor = 1'b0, ack = 1'b0, use_model = 1'b0;
   logic [1:0] piso = 2'd1;
   logic [13:0] cuenta_tb = '0, cnt_q, cuenta;
   logic ini, ped, en;
   logic [1:0] pr;
   int errors = 0, checks = 0;
   logic [2:0] sbq[$];
   vec_t tbl[22];
   always #5 clk = ~clk;
   supervisor_inactividad dut (
      .clockInt_150Hz_i(clk), .resetN_i(rst_n), .pedidos_i(pedidos), .motorActivo_i(motor),
      .pisoActual_i(piso), .cuenta_i(cuenta), .ackReposo_i(ack), .iniciaCuenta_o(ini),
      .pedidoReposo_o(ped), .pisoReposo_o(pr), .enReposo_o(en)
   );
   // Idle counter model: clears while iniciaCuenta is low, wraps at DIV-1.
   always @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= (!ini || cnt_q == DIV - 14'd1) ? 14'd0 : cnt_q + 14'd1;
   assign cuenta = use_model ? cnt_q : cuenta_tb;
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int n;
      logic ok;
      logic [2:0] e;
      //          pedidos  m     piso  cuenta      ack   {ini,ped,en}
      tbl[0]  = '{4'd0,  1'b0, 2'd1, 14'd0,    1'b0, 3'b001};
      tbl[1]  = '{4'd0,  1'b1, 2'd1, 14'd0,    1'b0, 3'b000};
      tbl[2]  = '{4'd0,  1'b0, 2'd3, 14'd0,    1'b0, 3'b100};
      tbl[3]  = '{4'd0,  1'b0, 2'd3, 14'd100,  1'b0, 3'b100};
      tbl[4]  = '{4'd0,  1'b0, 2'd3, 14'd9500, 1'b0, 3'b100};
      tbl[5]  = '{4'd4,  1'b0, 2'd3, 14'd8999, 1'b0, 3'b000};
      tbl[6]  = '{4'd0,  1'b0, 2'd3, 14'd0,    1'b0, 3'b100};
      tbl[7]  = '{4'd0,  1'b0, 2'd3, 14'd8999, 1'b0, 3'b010};
      tbl[8]  = '{4'd1,  1'b1, 2'd3, 14'd0,    1'b0, 3'b010};
      tbl[9]  = '{4'd0,  1'b0, 2'd3, 14'd0,    1'b1, 3'b000};
      tbl[10] = '{4'd0,  1'b1, 2'd2, 14'd0,    1'b0, 3'b000};
      tbl[11] = '{4'd0,  1'b1, 2'd2, 14'd0,    1'b1, 3'b000};
      tbl[12] = '{4'd0,  1'b0, 2'd2, 14'd0,    1'b0, 3'b000};
      tbl[13] = '{4'd0,  1'b0, 2'd1, 14'd0,    1'b0, 3'b001};
      tbl[14] = '{4'd0,  1'b0, 2'd1, 14'd0,    1'b1, 3'b001};
      tbl[15] = '{4'd2,  1'b0, 2'd1, 14'd0,    1'b0, 3'b000};
      tbl[16] = '{4'd0,  1'b0, 2'd2, 14'd0,    1'b0, 3'b100};
      tbl[17] = '{4'd0,  1'b0, 2'd2, 14'd8999, 1'b0, 3'b010};
      tbl[18] = '{4'd0,  1'b0, 2'd2, 14'd0,    1'b1, 3'b000};
      tbl[19] = '{4'd8,  1'b1, 2'd2, 14'd0,    1'b0, 3'b000};
      tbl[20] = '{4'd0,  1'b0, 2'd2, 14'd0,    1'b0, 3'b100};
      tbl[21] = '{4'd0,  1'b1, 2'd2, 14'd0,    1'b0, 3'b000};
      #12;
      chk("rst_ini", ini, 0);
      chk("rst_ped", ped, 0);
      chk("rst_en", en, 0);
      chk("rst_piso", pr, 1);
      @(negedge clk) rst_n = 1'b1;
      step();
      chk("first_edge_en", en, 1);
      chk("first_edge_ini", ini, 0);
      foreach (tbl[i]) begin
         @(negedge clk);
         pedidos = tbl[i].p; motor = tbl[i].m; piso = tbl[i].f; cuenta_tb = tbl[i].c; ack = tbl[i].a;
         sbq.push_back(tbl[i].e);
         step();
         e = sbq.pop_front();
         chk($sformatf("vec%0d", i), {ini, ped, en}, e);
         chk($sformatf("vec%0d_piso", i), pr, 1);
      end
      // Full idle minute on floor 3 with the counter model in the loop.
      @(negedge clk);
      pedidos = '0; motor = 1'b0; ack = 1'b0; piso = 2'd3; use_model = 1'b1;
      step();
      chk("idle_enter", ini, 1);
      n = 0;
      while (ped !== 1'b1 && n < 9100) begin
         step();
         n++;
      end
      chk("idle_latency", n, 9000);
      chk("idle_piso", pr, 1);
      chk("idle_cnt_wrap", cnt_q, 0);
      ok = 1'b1;
      repeat (20) begin
         step();
         ok &= ped;
      end
      chk("req_hold20", ok, 1);
      chk("req_cnt_held", cnt_q, 0);
      @(negedge clk) ack = 1'b1;
      step();
      chk("ack_drop", ped, 0);
      @(negedge clk);
      ack = 1'b0; motor = 1'b1;
      step();
      chk("traslado_motor", {ini, ped, en}, 0);
      @(negedge clk);
      motor = 1'b0; piso = 2'd1;
      step();
      chk("traslado_llega", en, 1);
      // Activity at cuenta=5000 on floor 2 aborts the idle minute.
      @(negedge clk);
      piso = 2'd2; pedidos = 4'd1;
      step();
      @(negedge clk) pedidos = '0;
      step();
      chk("cnt5000_enter", ini, 1);
      n = 0;
      while (cnt_q != 14'd5000 && n < 6000) begin
         step();
         n++;
      end
      chk("cnt5000_reached", cnt_q, 5000);
      pedidos = 4'b0100;
      step();
      chk("abort_ini", ini, 0);
      step();
      chk("abort_cnt", cnt_q, 0);
      ok = 1'b1;
      repeat (100) begin
         step();
         ok &= !ped;
      end
      chk("abort_no_req", ok, 1);
      // Reset pulsed while the request is pending.
      @(negedge clk);
      pedidos = '0; use_model = 1'b0; cuenta_tb = '0;
      step();
      chk("rq_contando", ini, 1);
      @(negedge clk) cuenta_tb = DIV - 14'd1;
      step();
      chk("rq_pending", ped, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("async_ped", ped, 0);
      chk("async_ini", ini, 0);
      chk("async_en", en, 0);
      chk("async_piso", pr, 1);
      @(negedge clk);
      rst_n = 1'b1; cuenta_tb = '0; use_model = 1'b1;
      step();
      chk("lat_enter", ini, 1);
      @(negedge clk) motor = 1'b1;
      n = 0;
      while (ini !== 1'b0 && n < 10) begin
         step();
         n++;
      end
      chk("act_latency", n, 1 + SYN);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
